approx_mul_accum: RTL and testbench

- Streaming accumulator placed directly downstream of the 32x32 unsigned approximate multiplier; its input is that multiplier's 64-bit product output.
- Sums a programmed number of consecutive products into a wide accumulator.
- Presents the sum, a saturation flag and a beat count on a valid/ready output.
- Used to build dot-product / MAC workloads on top of the approximate multiplier array.

---
 rtl/approx_mul_accum_if.sv | 55 +++++
 rtl/approx_mul_accum.sv | 113 +++++++++++
 tb/tb_approx_mul_accum.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_accum_if.sv
// Handshake bundle between the approximate-multiplier product stream and the accumulator.
// Carries the start/len command, the product valid/ready stream and the result valid/ready stream.
// The slave modport is the accumulator side; the master modport is the driver/consumer side.
//
// Signals:
//   start, len              command: begin an accumulation of len products
//   in_valid/in_ready/in_prod   product stream from the multiplier
//   out_valid/out_ready     result handshake
//   out_sum/out_sat/out_cnt result payload (sum, sticky saturation, beats accumulated)
//   busy                    accumulator is not idle
interface approx_mul_accum_if #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 80,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_sat;
    logic [LEN_W-1:0]  out_cnt;
    logic              busy;

    modport slave (
        input  start,
        input  len,
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_sat,
        output out_cnt,
        output busy
    );

    modport master (
        output start,
        output len,
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_sat,
        input  out_cnt,
        input  busy
    );
endinterface

// File: rtl/approx_mul_accum.sv
// Purpose: saturating streaming accumulator of a programmed number of multiplier products.
// Latency: result valid the cycle after the last accepted product (cycle after start when len==0).
// Backpressure: in_ready only while accumulating; the result is held until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any partial accumulation
//   bus    approx_mul_accum_if.slave: start/len command, product stream in, result stream out
module approx_mul_accum #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 80,  // must be >= PROD_W
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mul_accum_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [LEN_W-1:0]   rem_q,   rem_d;
    logic [LEN_W-1:0]   cnt_q,   cnt_d;
    logic               sat_q,   sat_d;

    // One extra bit so the carry out of the accumulator add is visible.
    logic [ACC_W:0]     sum_ext;

    assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    cnt_d = '0;
                    rem_d = bus.len;
                    // A zero-length request completes immediately with a zero result.
                    state_d = (bus.len == '0) ? DONE : ACC;
                end
            end

            ACC: begin
                if (bus.in_valid) begin
                    // Once saturated the accumulator is pinned to all-ones; adding to
                    // all-ones either carries or adds zero, so the sticky flag alone
                    // is enough to keep it there.
                    if (sum_ext[ACC_W] || sat_q) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // start is deliberately not looked at here: a new run must begin in IDLE.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Outputs come only from the registered state and datapath registers, so there is
    // no combinational path from the product stream to the result stream.
    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_sum   = acc_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_approx_mul_accum.sv
module tb_approx_mul_accum;

    localparam int PROD_W = 64;
    localparam int ACC_W  = 80;
    localparam int LEN_W  = 16;
    localparam int ACC2_W = 64;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_err    = 0;
    int hs_cnt   = 0;

    approx_mul_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC_W),  .LEN_W(LEN_W)) bus  ();
    approx_mul_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC2_W), .LEN_W(LEN_W)) bus2 ();

    approx_mul_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    approx_mul_accum #(.PROD_W(PROD_W), .ACC_W(ACC2_W), .LEN_W(LEN_W)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count product handshakes on the main instance.
    always @(posedge clk) begin
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of the products, clamped to the accumulator range.
    function automatic logic [127:0] model_sum(input logic [127:0] raw, input int w);
        logic [127:0] maxv;
        maxv = (128'(1) << w) - 128'(1);
        return (raw > maxv) ? maxv : raw;
    endfunction

    function automatic logic [127:0] model_sat(input logic [127:0] raw, input int w);
        logic [127:0] maxv;
        maxv = (128'(1) << w) - 128'(1);
        return (raw > maxv) ? 128'(1) : 128'(0);
    endfunction

    task automatic check_result(input string tag, input logic [127:0] raw, input int n);
        chk({tag, " out_valid"}, 128'(bus.out_valid), 128'(1));
        chk({tag, " out_sum"},   128'(bus.out_sum),   model_sum(raw, ACC_W));
        chk({tag, " out_sat"},   128'(bus.out_sat),   model_sat(raw, ACC_W));
        chk({tag, " out_cnt"},   128'(bus.out_cnt),   128'(n));
    endtask

    // Random run: random products, random bubbles, random over-supply and result stall.
    task automatic run_rand(input string tag, input int n);
        logic [127:0] raw;
        logic [63:0]  p;
        logic         v;
        int           base;
        int           taken;
        int           cyc;
        raw   = '0;
        taken = 0;
        cyc   = 0;
        base  = hs_cnt;
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        tick();
        bus.start = 1'b0;
        while (taken < n && cyc < 200) begin
            v = ($urandom_range(0, 3) != 0);
            p = {$urandom, $urandom};
            bus.in_valid = v;
            bus.in_prod  = p;
            if (v) begin
                chk({tag, " in_ready"}, 128'(bus.in_ready), 128'(1));
                raw = raw + 128'(p);
                taken++;
            end
            tick();
            cyc++;
        end
        // Keep offering products past the programmed length.
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_prod  = {$urandom, $urandom};
        check_result(tag, raw, n);
        repeat ($urandom_range(0, 3)) begin
            tick();
            chk({tag, " hold out_valid"}, 128'(bus.out_valid), 128'(1));
            chk({tag, " hold out_sum"},   128'(bus.out_sum),   model_sum(raw, ACC_W));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, " beats"},        128'(hs_cnt - base),  128'(n));
        chk({tag, " out_valid lo"}, 128'(bus.out_valid),  128'(0));
        chk({tag, " busy lo"},      128'(bus.busy),       128'(0));
        chk({tag, " sum kept"},     128'(bus.out_sum),    model_sum(raw, ACC_W));
    endtask

    initial begin
        int base;
        logic [63:0] ones64;
        ones64 = '1;

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.in_valid   = 1'b0;
        bus.in_prod    = '0;
        bus.out_ready  = 1'b0;
        bus2.start     = 1'b0;
        bus2.len       = '0;
        bus2.in_valid  = 1'b0;
        bus2.in_prod   = '0;
        bus2.out_ready = 1'b0;

        // ---------------- reset state
        #12;
        chk("rst in_ready",  128'(bus.in_ready),  128'(0));
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst busy",      128'(bus.busy),      128'(0));
        chk("rst out_sum",   128'(bus.out_sum),   128'(0));
        chk("rst out_cnt",   128'(bus.out_cnt),   128'(0));
        chk("rst out_sat",   128'(bus.out_sat),   128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- basic sum 5+7+11
        base = hs_cnt;
        bus.start = 1'b1;
        bus.len   = 16'd3;
        tick();
        bus.start = 1'b0;
        chk("basic in_ready", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd5;
        tick();
        bus.in_prod  = 64'd7;
        tick();
        bus.in_prod  = 64'd11;
        chk("basic not yet valid", 128'(bus.out_valid), 128'(0));
        tick();
        bus.in_valid = 1'b0;
        check_result("basic", 128'd23, 3);
        chk("basic beats", 128'(hs_cnt - base), 128'(3));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("basic idle out_valid", 128'(bus.out_valid), 128'(0));
        chk("basic idle busy",      128'(bus.busy),      128'(0));
        chk("basic sum kept",       128'(bus.out_sum),   128'd23);

        // ---------------- bubbles and backpressure
        bus.start = 1'b1;
        bus.len   = 16'd2;
        tick();
        bus.start   = 1'b0;
        bus.in_prod = ones64;
        bus.in_valid = 1'b0; tick();
        bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0; tick();
        bus.in_valid = 1'b0; tick();
        chk("bubble still acc", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1; tick();
        bus.in_valid = 1'b0;
        check_result("bubble", 128'h1_FFFF_FFFF_FFFF_FFFE, 2);
        repeat (4) begin
            tick();
            chk("bubble hold valid", 128'(bus.out_valid), 128'(1));
            chk("bubble hold sum",   128'(bus.out_sum),   128'h1_FFFF_FFFF_FFFF_FFFE);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bubble idle busy", 128'(bus.busy), 128'(0));

        // ---------------- saturation on the 64-bit accumulator build
        bus2.start = 1'b1;
        bus2.len   = 16'd2;
        tick();
        bus2.start    = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_prod  = 64'hFFFF_FFFF_FFFF_FFF0;
        tick();
        bus2.in_prod  = 64'h20;
        tick();
        bus2.in_valid = 1'b0;
        chk("sat out_valid", 128'(bus2.out_valid), 128'(1));
        chk("sat out_sum",   128'(bus2.out_sum),
            model_sum(128'h1_0000_0000_0000_0010, ACC2_W));
        chk("sat out_sat",   128'(bus2.out_sat),
            model_sat(128'h1_0000_0000_0000_0010, ACC2_W));
        chk("sat out_cnt",   128'(bus2.out_cnt),   128'(2));
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;

        // ---------------- zero length with in_valid high
        base = hs_cnt;
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd77;
        bus.start    = 1'b1;
        bus.len      = 16'd0;
        chk("zero in_ready idle", 128'(bus.in_ready), 128'(0));
        tick();
        bus.start = 1'b0;
        chk("zero in_ready", 128'(bus.in_ready), 128'(0));
        check_result("zero", 128'd0, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("zero beats", 128'(hs_cnt - base), 128'(0));

        // ---------------- ignored start and over-supply
        base = hs_cnt;
        bus.start = 1'b1;
        bus.len   = 16'd4;
        tick();
        bus.in_valid = 1'b1;
        bus.start    = 1'b0;
        bus.in_prod  = 64'd100; tick();
        bus.start    = 1'b1;
        bus.len      = 16'd7;
        bus.in_prod  = 64'd200; tick();
        bus.start    = 1'b0;
        bus.in_prod  = 64'd300; tick();
        bus.in_prod  = 64'd400; tick();
        bus.in_prod  = 64'd999;
        check_result("ovr", 128'd1000, 4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ovr still done", 128'(bus.out_valid), 128'(1));
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        chk("ovr busy", 128'(bus.busy), 128'(0));
        tick();
        bus.in_valid = 1'b0;
        chk("ovr stays idle", 128'(bus.busy), 128'(0));
        chk("ovr beats", 128'(hs_cnt - base), 128'(4));
        chk("ovr cnt kept", 128'(bus.out_cnt), 128'(4));

        // ---------------- reset mid-run
        bus.start = 1'b1;
        bus.len   = 16'd5;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd40; tick();
        bus.in_prod  = 64'd50; tick();
        bus.in_valid = 1'b0;
        chk("mid acc cnt", 128'(bus.out_cnt), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready",  128'(bus.in_ready),  128'(0));
        chk("mid rst busy",      128'(bus.busy),      128'(0));
        chk("mid rst out_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post rst busy",    128'(bus.busy),    128'(0));
        chk("post rst out_sum", 128'(bus.out_sum), 128'(0));
        chk("post rst out_cnt", 128'(bus.out_cnt), 128'(0));
        tick();
        chk("post rst no result", 128'(bus.out_valid), 128'(0));
        bus.start = 1'b1;
        bus.len   = 16'd1;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'd9;
        tick();
        bus.in_valid = 1'b0;
        check_result("fresh", 128'd9, 1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // ---------------- randomized runs against the reference sum
        for (int r = 0; r < 8; r++) begin
            run_rand($sformatf("rand%0d", r), $urandom_range(1, 8));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
